// File: rtl/serial_addsub_if.sv
// Handshake and result bundle for the digit-serial adder/subtractor.
//
// Handshake: the requester holds start high with mode/a/b/cin valid; the
// transfer happens on the first rising clk edge where start=1 and ready=1.
// A start seen while ready=0 is dropped (not queued). done is a one-cycle
// pulse in the cycle in which result/cout/ovf/zero have just been updated;
// those outputs then hold until the next operation completes.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b, cin,
    input  ready, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b, cin,
    output ready, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are captured on an accepted start,
// then DIGIT bits are processed per clock, LSB digit first, with the
// carry/borrow rippling through c_q between cycles. Result and flags are
// committed together on the edge that processes the last digit.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus,
  output logic            dbg_state   // 0 = IDLE, 1 = RUN
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic             mode_q, c_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig;
  logic             c_out, c_msb_in;
  logic             last, accept;

  assign last      = (cnt == CW'(N - 1));
  assign accept    = (state == IDLE) && bus.start;
  assign bus.ready = (state == IDLE);
  assign dbg_state = (state == RUN);

  // One digit of ripple add/subtract; also records the carry entering the top bit
  always_comb begin
    logic c, x, y;
    c        = c_q;
    x        = 1'b0;
    y        = 1'b0;
    dig      = '0;
    c_msb_in = c_q;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = c;
      x        = a_sh[i];
      y        = b_sh[i];
      dig[i]   = x ^ y ^ c;
      if (mode_q) c = (~x & y) | (c & ~(x ^ y));
      else        c = (x & y) | (c & (x ^ y));
    end
    c_out  = c;
    // New digit enters at the top; after N digits the LSB digit sits at bit 0
    acc_nx = (acc >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept in IDLE, return to IDLE after the last digit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit shifting and the final commit of result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      mode_q     <= 1'b0;
      c_q        <= 1'b0;
      cnt        <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.zero   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        mode_q <= bus.mode;
        c_q    <= bus.cin;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> DIGIT;
        b_sh <= b_sh >> DIGIT;
        acc  <= acc_nx;
        c_q  <= c_out;
        cnt  <= cnt + CW'(1);
        if (last) begin
          bus.result <= acc_nx;
          bus.cout   <= c_out;
          bus.ovf    <= c_msb_in ^ c_out;
          bus.zero   <= (acc_nx == '0);
          bus.done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8) share
// clock and reset. Expected {result,cout,ovf,zero} words go into a queue per
// instance when an operation is driven; a monitor pops and compares on done.
module tb_serial_addsub;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus  ();
  serial_addsub_if #(.WIDTH(W)) bus4 ();
  logic dbg1, dbg4;

  serial_addsub #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg1)
  );
  serial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  logic [W+2:0] exp4_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: exact unsigned and signed arithmetic on integers
  function automatic logic [W+2:0] model(logic m, logic [W-1:0] a, logic [W-1:0] b, logic ci);
    int ua = int'(a);
    int ub = int'(b);
    int sa = a[W-1] ? int'(a) - 256 : int'(a);
    int sb = b[W-1] ? int'(b) - 256 : int'(b);
    int u, s;
    logic co, ov;
    logic [W-1:0] r;
    if (!m) begin
      u  = ua + ub + int'(ci);
      s  = sa + sb + int'(ci);
      co = (u > 255);
    end else begin
      u  = ua - ub - int'(ci);
      s  = sa - sb - int'(ci);
      co = (u < 0);
    end
    r  = u[W-1:0];
    ov = (s > 127) || (s < -128);
    return {r, co, ov, (r == '0)};
  endfunction

  // Monitors: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) check("spurious_done_d1", 32'd1, 32'd0);
      else check("result_d1", {bus.result, bus.cout, bus.ovf, bus.zero}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.done) begin
      if (exp4_q.size() == 0) check("spurious_done_d4", 32'd1, 32'd0);
      else check("result_d4", {bus4.result, bus4.cout, bus4.ovf, bus4.zero}, exp4_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(int sel);
    return (sel != 0) ? bus4.ready : bus.ready;
  endfunction

  function automatic logic dn(int sel);
    return (sel != 0) ? bus4.done : bus.done;
  endfunction

  task automatic drive(int sel, logic s, logic m, logic [W-1:0] a, logic [W-1:0] b, logic ci);
    if (sel != 0) begin
      bus4.start = s; bus4.mode = m; bus4.a = a; bus4.b = b; bus4.cin = ci;
    end else begin
      bus.start = s; bus.mode = m; bus.a = a; bus.b = b; bus.cin = ci;
    end
  endtask

  task automatic push(int sel, logic [W+2:0] e);
    if (sel != 0) exp4_q.push_back(e);
    else          exp_q.push_back(e);
  endtask

  // Runs one op; called and returns at #1 after a posedge. Checks that ready
  // and done stay low for N cycles and both rise exactly N edges after start.
  task automatic run_op(int sel, logic m, logic [W-1:0] a, logic [W-1:0] b, logic ci,
                        logic [W+2:0] e);
    int n = (sel != 0) ? 2 : 8;
    int waited = 0;
    logic ok = 1'b1;
    while (!rdy(sel) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rdy(sel)) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    drive(sel, 1'b1, m, a, b, ci);
    push(sel, e);
    @(posedge clk); #1;
    // Scramble the operand inputs: they must not affect the op in flight
    drive(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    for (int k = 0; k < n; k++) begin
      if (dn(sel) || rdy(sel)) ok = 1'b0;
      @(posedge clk); #1;
    end
    if (!(dn(sel) && rdy(sel))) ok = 1'b0;
    check((sel != 0) ? "latency_d4" : "latency_d1", 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int gap;
    logic m, ci;
    logic [W-1:0] ra, rb;

    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 8'h06, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_d1", {bus.result, bus.cout, bus.ovf, bus.zero, bus.done, bus.ready, dbg1},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("reset_d4", {bus4.result, bus4.cout, bus4.ovf, bus4.zero, bus4.done, bus4.ready, dbg4},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors on the bit-serial instance
    for (int i = 0; i < 10; i++)
      run_op(0, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin,
             {vecs[i].r, vecs[i].co, vecs[i].ov, vecs[i].z});

    // start pulsed mid-RUN with other operands must be ignored
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
    push(0, {8'h33, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    gap = 0;
    while (!bus.done && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    check("midrun_done_seen", 32'(bus.done), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("midrun_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back: start in the done cycle, second done 9 cycles later
    run_op(0, 1'b0, 8'h40, 8'h05, 1'b0, model(1'b0, 8'h40, 8'h05, 1'b0));
    drive(0, 1'b1, 1'b1, 8'h90, 8'h10, 1'b1);
    push(0, model(1'b1, 8'h90, 8'h10, 1'b1));
    gap = 0;
    do begin
      @(posedge clk); #1;
      if (gap == 0) drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      gap++;
    end while (!bus.done && gap < 20);
    check("b2b_gap", 32'(gap), 32'd9);

    // Async reset in the middle of RUN discards the op
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h55, 8'h0F, 1'b0);
    push(0, model(1'b0, 8'h55, 8'h0F, 1'b0));
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {bus.result, bus.cout, bus.ovf, bus.zero, bus.done, bus.ready, dbg1},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run_op(0, 1'b1, 8'hC8, 8'h37, 1'b0, model(1'b1, 8'hC8, 8'h37, 1'b0));

    // DIGIT=4 instance: table vector plus a few directed ones
    run_op(1, 1'b0, 8'h3C, 8'hC4, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++)
      run_op(1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin,
             {vecs[i].r, vecs[i].co, vecs[i].ov, vecs[i].z});

    // Random ops, 1000 per mode on each instance
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 2000; i++) begin
        m  = (i >= 1000);
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        ci = 1'($urandom_range(0, 1));
        run_op(sel, m, ra, rb, ci, model(m, ra, rb, ci));
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_queues_empty", 32'(exp_q.size() + exp4_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
